// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch stage: owns the PC, reads two consecutive imem words per cycle,
// and predicts beq/bne with a table of 2-bit saturating counters.
module dual_fetch_unit #(
  parameter int         BHT_BITS = 4,
  parameter logic [5:0] BEQ_OP   = 6'h04,
  parameter logic [5:0] BNE_OP   = 6'h05
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr1,
  output logic [7:0]  imem_addr2,
  input  logic [31:0] imem_data1,
  input  logic [31:0] imem_data2,
  input  logic        stall_outer,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        upd_valid,
  input  logic [7:0]  upd_pc,
  input  logic        upd_taken,
  output logic [31:0] inst1_Fetch,
  output logic [31:0] inst2_Fetch,
  output logic [7:0]  pcF,
  output logic [7:0]  pcPlus1F,
  output logic [7:0]  pcPlus2_F,
  output logic [7:0]  pcBranchF,
  output logic [7:0]  pcBranchF_inst2,
  output logic        predictionF_1,
  output logic        predictionF_2
);

  localparam int BHT_N = 1 << BHT_BITS;

  function automatic logic is_branch(input logic [31:0] inst);
    return (inst[31:26] == BEQ_OP) || (inst[31:26] == BNE_OP);
  endfunction

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  logic [7:0]          pc_p0;
  logic [7:0]          pc_next;
  logic [1:0]          bht [BHT_N];
  logic [7:0]          pc_plus1;
  logic [7:0]          pc_plus2;
  logic [7:0]          tgt1;
  logic [7:0]          tgt2;
  logic [BHT_BITS-1:0] idx1;
  logic [BHT_BITS-1:0] idx2;
  logic [BHT_BITS-1:0] upd_idx;
  logic                pred1;
  logic                pred2;
  logic                unused_upd_hi;

  // Fetch stage: everything below is combinational from pc_p0, imem data and the BHT
  assign pc_plus1 = pc_p0 + 8'd1;
  assign pc_plus2 = pc_p0 + 8'd2;
  assign tgt1     = pc_plus1 + imem_data1[7:0];
  assign tgt2     = pc_plus2 + imem_data2[7:0];
  assign idx1     = pc_p0[BHT_BITS-1:0];
  assign idx2     = pc_plus1[BHT_BITS-1:0];
  assign upd_idx  = upd_pc[BHT_BITS-1:0];
  assign unused_upd_hi = ^upd_pc[7:BHT_BITS];

  // Slot 2 only predicts when slot 1 falls through, since slot 2 is squashed otherwise
  assign pred1 = is_branch(imem_data1) && bht[idx1][1];
  assign pred2 = !pred1 && is_branch(imem_data2) && bht[idx2][1];

  assign imem_addr1      = pc_p0;
  assign imem_addr2      = pc_plus1;
  assign pcF             = pc_p0;
  assign pcPlus1F        = pc_plus1;
  assign pcPlus2_F       = pc_plus2;
  assign pcBranchF       = tgt1;
  assign pcBranchF_inst2 = tgt2;
  assign predictionF_1   = pred1;
  assign predictionF_2   = pred2;
  assign inst1_Fetch     = imem_data1;
  assign inst2_Fetch     = pred1 ? 32'd0 : imem_data2;

  always_comb begin
    pc_next = pc_plus2;
    if (redirect_valid)   pc_next = redirect_pc;
    else if (stall_outer) pc_next = pc_p0;
    else if (pred1)       pc_next = tgt1;
    else if (pred2)       pc_next = tgt2;
  end

  // PC register boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_p0 <= 8'd0;
    else        pc_p0 <= pc_next;
  end

  // Training is independent of stall/redirect; same-index reads see the old value this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      bht[upd_idx] <= sat_ctr(bht[upd_idx], upd_taken);
    end
  end

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed bench for dual_fetch_unit with a per-cycle reference model of PC flow and BHT.
module tb_dual_fetch_unit;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  imem_addr1, imem_addr2;
  logic [31:0] imem_data1, imem_data2;
  logic        stall_outer = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic        upd_valid = 1'b0;
  logic [7:0]  upd_pc = 8'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] inst1_Fetch, inst2_Fetch;
  logic [7:0]  pcF, pcPlus1F, pcPlus2_F, pcBranchF, pcBranchF_inst2;
  logic        predictionF_1, predictionF_2;

  logic [31:0] mem [256];
  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;
  int m_pc;
  int m_bht [N];

  dual_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
    .imem_data1(imem_data1), .imem_data2(imem_data2),
    .stall_outer(stall_outer), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .inst1_Fetch(inst1_Fetch), .inst2_Fetch(inst2_Fetch),
    .pcF(pcF), .pcPlus1F(pcPlus1F), .pcPlus2_F(pcPlus2_F),
    .pcBranchF(pcBranchF), .pcBranchF_inst2(pcBranchF_inst2),
    .predictionF_1(predictionF_1), .predictionF_2(predictionF_2)
  );

  assign imem_data1 = mem[imem_addr1];
  assign imem_data2 = mem[imem_addr2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_isbr(input logic [31:0] w);
    int op;
    op = int'(w / 32'h0400_0000);
    return (op == 4) || (op == 5);
  endfunction

  function automatic int m_pc2();
    return (m_pc + 1) % 256;
  endfunction

  function automatic bit m_p1();
    return m_isbr(mem[m_pc]) && (m_bht[m_pc % N] >= 2);
  endfunction

  function automatic bit m_p2();
    return !m_p1() && m_isbr(mem[m_pc2()]) && (m_bht[m_pc2() % N] >= 2);
  endfunction

  function automatic int m_tgt1();
    return (m_pc + 1 + int'(mem[m_pc] % 256)) % 256;
  endfunction

  function automatic int m_tgt2();
    return (m_pc + 2 + int'(mem[m_pc2()] % 256)) % 256;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 0;
      for (int i = 0; i < N; i++) m_bht[i] = 1;
    end else begin
      int npc;
      int k;
      if (redirect_valid)   npc = int'(redirect_pc);
      else if (stall_outer) npc = m_pc;
      else if (m_p1())      npc = m_tgt1();
      else if (m_p2())      npc = m_tgt2();
      else                  npc = (m_pc + 2) % 256;
      if (upd_valid) begin
        k = int'(upd_pc) % N;
        if (upd_taken && m_bht[k] < 3)       m_bht[k] = m_bht[k] + 1;
        else if (!upd_taken && m_bht[k] > 0) m_bht[k] = m_bht[k] - 1;
      end
      m_pc = npc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pcF", pcF, m_pc);
      chk("pcPlus1F", pcPlus1F, m_pc2());
      chk("pcPlus2_F", pcPlus2_F, (m_pc + 2) % 256);
      chk("imem_addr1", imem_addr1, m_pc);
      chk("imem_addr2", imem_addr2, m_pc2());
      chk("inst1_Fetch", inst1_Fetch, mem[m_pc]);
      chk("inst2_Fetch", inst2_Fetch, m_p1() ? 32'd0 : mem[m_pc2()]);
      chk("pcBranchF", pcBranchF, m_tgt1());
      chk("pcBranchF_inst2", pcBranchF_inst2, m_tgt2());
      chk("predictionF_1", predictionF_1, m_p1());
      chk("predictionF_2", predictionF_2, m_p2());
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | 32'(i);
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_pcF", pcF, 8'd0);
    chk("rst_pcPlus1F", pcPlus1F, 8'd1);
    chk("rst_pcPlus2_F", pcPlus2_F, 8'd2);
    chk("rst_addr2", imem_addr2, 8'd1);
    reset = 1'b1;

    repeat (127) step();
    chk("wrap_pcF", pcF, 8'd254);
    chk("wrap_pcPlus1F", pcPlus1F, 8'd255);
    chk("wrap_pcPlus2_F", pcPlus2_F, 8'd0);
    step();
    chk("wrap_next", pcF, 8'd0);

    mem[4] = 32'h1000_0010;
    step(); step();
    chk("cold_pred1", predictionF_1, 1'b0);
    step();
    chk("cold_next", pcF, 8'd6);
    upd_valid = 1'b1; upd_pc = 8'd4; upd_taken = 1'b1;
    step(); step();
    upd_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    chk("redirect_same_cycle", pcF, 8'd10);
    step();
    redirect_valid = 1'b0;
    chk("hot_pred1", predictionF_1, 1'b1);
    chk("hot_target", pcBranchF, 8'h15);
    chk("hot_squash", inst2_Fetch, 32'd0);
    step();
    chk("hot_next", pcF, 8'h15);

    mem[9] = 32'h1000_0003;
    upd_valid = 1'b1; upd_pc = 8'd9; upd_taken = 1'b1;
    step();
    upd_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'd8;
    step();
    redirect_valid = 1'b0;
    chk("s2_pred1", predictionF_1, 1'b0);
    chk("s2_pred2", predictionF_2, 1'b1);
    chk("s2_target", pcBranchF_inst2, 8'h0D);
    step();
    chk("s2_next", pcF, 8'h0D);

    redirect_valid = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_valid = 1'b0;
    stall_outer = 1'b1;
    repeat (3) begin
      step();
      chk("stall_hold", pcF, 8'h20);
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0; stall_outer = 1'b0;
    chk("stall_redirect", pcF, 8'h40);

    mem[3] = 32'h1000_0020;
    redirect_valid = 1'b1; redirect_pc = 8'd3;
    step();
    redirect_valid = 1'b0;
    stall_outer = 1'b1;
    upd_valid = 1'b1; upd_pc = 8'd3; upd_taken = 1'b0;
    repeat (5) begin
      step();
      chk("sat_low", predictionF_1, 1'b0);
    end
    upd_taken = 1'b1;
    step();
    chk("sat_inc1", predictionF_1, 1'b0);
    step();
    chk("sat_inc2", predictionF_1, 1'b1);
    upd_taken = 1'b0;
    chk("same_cycle_old", predictionF_1, 1'b1);
    step();
    chk("same_cycle_new", predictionF_1, 1'b0);
    upd_valid = 1'b0; stall_outer = 1'b0;
    step();
    chk("alias_slot2_next", pcF, 8'h15);

    redirect_valid = 1'b1; redirect_pc = 8'h50;
    step();
    chk("pre_rst_pc", pcF, 8'h50);
    redirect_pc = 8'h70;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pcF", pcF, 8'd0);
    chk("async_rst_pcPlus2", pcPlus2_F, 8'd2);
    redirect_valid = 1'b0;
    step();
    chk("rst_hold", pcF, 8'd0);
    reset = 1'b1;
    step();
    chk("post_rst_next", pcF, 8'd2);
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    step();
    redirect_valid = 1'b0;
    chk("bht_rst_4", predictionF_1, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 8'd8;
    step();
    redirect_valid = 1'b0;
    chk("bht_rst_9", predictionF_2, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dual_fetch_unit.md
Name: dual_fetch_unit

Overview:
Dual-issue fetch stage that produces the instruction pair and per-slot PCs, branch targets and predictions consumed by the fetch/decode pipeline register. It owns the 8-bit PC register and reads two consecutive instruction-memory words per cycle. It predicts conditional branches with a table of 2-bit saturating counters and accepts redirects from downstream flush logic.

Parameters:
BHT_BITS, 4, log2 of branch-history-table entries; index = PC[BHT_BITS-1:0]
BEQ_OP, 6'h04, opcode (inst[31:26]) of beq
BNE_OP, 6'h05, opcode of bne

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_addr1  out  8  instruction-memory address, slot 1 (= pcF)
imem_addr2  out  8  instruction-memory address, slot 2 (= pcF+1)
imem_data1  in  32  combinational read data for imem_addr1
imem_data2  in  32  combinational read data for imem_addr2
stall_outer  in  1  hold PC, no new fetch
redirect_valid  in  1  downstream flush (J/JR/branch mispredict); load redirect_pc
redirect_pc  in  8  corrected fetch PC
upd_valid  in  1  resolved conditional branch; train BHT
upd_pc  in  8  PC of the resolved branch
upd_taken  in  1  actual outcome of the resolved branch
inst1_Fetch  out  32  slot-1 instruction
inst2_Fetch  out  32  slot-2 instruction (0 when squashed)
pcF  out  8  PC of slot 1
pcPlus1F  out  8  PC of slot 2
pcPlus2_F  out  8  pcF+2
pcBranchF  out  8  slot-1 branch target
pcBranchF_inst2  out  8  slot-2 branch target
predictionF_1  out  1  slot-1 predicted taken
predictionF_2  out  1  slot-2 predicted taken

Behaviour:
- PC register is the only fetch-path state; all fetch outputs are combinational from the PC register, imem data and the BHT.
- All PC arithmetic is 8-bit and wraps mod 256: pcPlus1F=pcF+1, pcPlus2_F=pcF+2, pcBranchF=pcF+1+inst1[7:0], pcBranchF_inst2=pcPlus1F+1+inst2[7:0].
- isbr(x) = (x[31:26]==BEQ_OP)||(x[31:26]==BNE_OP).
- predictionF_1 = isbr(imem_data1) && BHT[pcF][1].
- predictionF_2 = !predictionF_1 && isbr(imem_data2) && BHT[pcPlus1F][1].
- inst1_Fetch = imem_data1. inst2_Fetch = predictionF_1 ? 0 : imem_data2, so the slot after a predicted-taken branch is squashed.
- Next-PC priority on each rising edge:
  1. redirect_valid: redirect_pc. This overrides stall_outer.
  2. stall_outer: hold.
  3. predictionF_1: pcBranchF.
  4. predictionF_2: pcBranchF_inst2.
  5. Otherwise: pcF+2.
- redirect_valid does not change outputs in the cycle it is asserted. The downstream register flushes that cycle; new-PC outputs appear the following cycle.
- BHT: 2^BHT_BITS entries of 2 bits.
  - Each entry resets to 2'b01 (weakly not-taken).
  - When upd_valid=1, entry upd_pc[BHT_BITS-1:0] increments (saturating at 3) if upd_taken, else decrements (saturating at 0).
  - Updates proceed regardless of stall_outer and redirect_valid.
- Same-cycle BHT read and update of one index: the prediction uses the pre-update value; the new value is visible next cycle.
- Two fetch slots aliasing to the same BHT index each read that entry independently.
- Reset (async, any time, including mid-stall or mid-redirect): PC=0 and all BHT entries=01.
  - With PC=0: pcF=0, pcPlus1F=1, pcPlus2_F=2, imem_addr1=0, imem_addr2=1.
  - Instruction, target and prediction outputs follow imem data at PC 0.
  - The first fetch after release is from PC 0.

Test Plan:
- Reset, imem all non-branch -> pcF sequence 0,2,4,...; at pcF=254 the next pcF is 0 (wrap); pcPlus1F=255 and pcPlus2_F=0 at pcF=254.
- inst1 = beq with imm 8'h10 at PC 4, BHT[4]=01 -> not predicted, next pcF=6. Two upd_valid/upd_taken=1 at upd_pc=4 -> BHT[4]=11. Refetch PC 4 -> predictionF_1=1, pcBranchF=8'h15, inst2_Fetch=0, next pcF=8'h15.
- beq in slot 2 at PC 9 with BHT[9]=1x and imm 8'h03 -> predictionF_1=0, predictionF_2=1, pcBranchF_inst2=8'h0D, next pcF=8'h0D.
- stall_outer=1 for 3 cycles at pcF=8'h20 -> pcF holds 8'h20; redirect_valid=1 with redirect_pc=8'h40 during the stall -> pcF=8'h40 next cycle.
- Saturation: 5 upd_taken=0 on index 3 -> counter reaches 00 and stays there. Same-cycle update with fetch at that index -> prediction reflects the old value.
- Assert reset mid-redirect at pcF=8'h50 -> pcF=0 immediately, BHT entries read 01, fetch resumes at 0 after release.
